ddnf_dknf_9_4: RTL and testbench
================================

DDNF_DKNF_9_4 -- requirements
Module: ddnf_dknf_9_4

Interface
REG-parameters: none; N_IN=9, N_OUT=4 are fixed constants, not parameters.
REQ-001 SHALL have port clk, input, 1 bit: single clock, rising edge active.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports x0..x8, input, 1 bit each.
- Input vector index is n = sum(x_k * 2^k); x0 is the LSB.
REQ-004 SHALL have ports y_ddnf0..y_ddnf3, output, 1 bit each.
- Registered result of the disjunctive canonical form (sum of minterms).
- y_ddnf0 is the MSB.
REQ-005 SHALL have ports y_dknf0..y_dknf3, output, 1 bit each.
- Registered result of the conjunctive canonical form (product of maxterms).
- y_dknf0 is the MSB.
REQ-006 SHALL have port err, output, 1 bit: registered flag, 1 when the DDNF and DKNF results differ.

Function
REQ-007 SHALL implement the truth table T(n) = popcount(x0..x8), range 0..9.
- T(n) is encoded as 4 bits {y0,y1,y2,y3}, y0 MSB.
- For 512 inputs, T(n) is defined for every n with no don't-cares.
REQ-008 SHALL compute each DDNF output bit j as the OR of all 9-literal minterms m_n for which bit j of T(n) is 1.
REQ-009 SHALL compute each DKNF output bit j as the AND of all 9-literal maxterms M_n for which bit j of T(n) is 0.
REQ-010 SHALL NOT derive either form from adders or a lookup memory.
- Both forms are canonical sum-of-minterms / product-of-maxterms logic.
- Loop-generated terms are permitted.
REQ-011 SHALL sample all x inputs on each rising clk edge.
- y_ddnf, y_dknf and err reflect those inputs after the edge: latency 1 cycle, throughput 1 vector per cycle.
REQ-012 SHALL compute err as OR over j of (ddnf_j XOR dknf_j), from the same combinational values that are registered.
REQ-013 SHALL accept any input change every cycle, with no handshake and no state beyond the output registers.
REQ-014 Boundary conditions:
- n=0 SHALL give 0000.
- n=511 SHALL give 1001.
- Values 1010..1111 SHALL never appear on the outputs.

Reset
REQ-015 When rst=1 at a rising clk edge, the block SHALL set all y_ddnf, all y_dknf and err to 0, ignoring x.
REQ-016 On the first edge with rst=0, the block SHALL register the function of the current x.
- Reset asserted mid-sweep SHALL only clear the outputs; the block has no other state.

Structure
REQ-017 A shared package SHALL hold:
- N_IN=9 and N_OUT=4;
- a function or constant giving T(n) for n = 0..511;
- the minterm/maxterm literal-polarity helper.
REQ-018 One sub-module SHALL be instantiated once per output bit per form: nf_term_eval.
- Parameters: form (SOP/POS) and the 512-bit truth column.
- Behaviour: evaluates the canonical expression for 9 inputs.
REQ-019 The top level SHALL contain only:
- 8 nf_term_eval instances;
- the err XOR/OR tree;
- the output register with synchronous reset.

Verification
REQ-020 Reset: rst=1 with x=111111111 for one edge SHALL give all outputs and err = 0; after rst=0 and one edge, y_ddnf=y_dknf=1001.
REQ-021 Exhaustive sweep: apply n=0..511, one per cycle. Each cycle-delayed y_ddnf and y_dknf SHALL equal popcount(n), and err SHALL be 0 throughout.
REQ-022 Directed points, each with y_ddnf=y_dknf as given:
- n=0 -> 0000
- n=7 -> 0011
- n=256 (x8 only) -> 0001
- n=255 -> 1000
- n=510 -> 1000
REQ-023 Latency: change x from 0 to 511 in a single cycle. Outputs SHALL read 0000 at that edge and 1001 exactly one edge later.
REQ-024 Mid-sweep reset: assert rst at n=300 for one cycle. Outputs SHALL be 0000 with err=0 for that edge, then resume with T(301) on the next edge.

Source files
------------

// File: rtl/ddnf_dknf_9_4_pkg.sv
// Shared constants, truth table and literal-polarity helper for the 9-in/4-out
// canonical-form block.
package ddnf_dknf_9_4_pkg;

  localparam int unsigned N_IN    = 9;
  localparam int unsigned N_OUT   = 4;
  localparam int unsigned N_TERMS = 1 << N_IN;

  // Which canonical form an evaluator builds.
  typedef enum logic [0:0] {
    FormSop,  // OR of minterms
    FormPos   // AND of maxterms
  } nf_form_e;

  // Truth table value T(n): number of ones in the 9-bit index.
  // This is only evaluated at elaboration time to build the truth columns.
  function automatic logic [N_OUT-1:0] t_of(input int unsigned n);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      cnt += (n >> k) & 32'd1;
    end
    return N_OUT'(cnt);
  endfunction

  // Truth column for output bit j, where j = 0 is the MSB of T(n).
  function automatic logic [N_TERMS-1:0] truth_col(input int unsigned j);
    logic [N_TERMS-1:0] col;
    logic [N_OUT-1:0]   t;
    col = '0;
    for (int unsigned n = 0; n < N_TERMS; n++) begin
      t      = t_of(n);
      col[n] = logic'((t >> (N_OUT - 1 - j)) & 4'd1);
    end
    return col;
  endfunction

  // Literal polarity for variable k in term n: 1 means the literal is x_k,
  // 0 means ~x_k. A minterm is true exactly at n; a maxterm is false exactly at n.
  function automatic logic lit_pol(input int unsigned n, input int unsigned k,
                                   input nf_form_e form);
    logic b;
    b = logic'((n >> k) & 32'd1);
    return (form == FormSop) ? b : ~b;
  endfunction

endpackage

// File: rtl/nf_term_eval.sv
// Canonical normal-form evaluator for one output bit: either the OR of all
// minterms whose column bit is 1, or the AND of all maxterms whose column bit is 0.
module nf_term_eval
  import ddnf_dknf_9_4_pkg::*;
#(
  parameter nf_form_e             Form   = FormSop,
  parameter logic [N_TERMS-1:0]   Column = '0
) (
  input  logic [N_IN-1:0] x_i,
  output logic            y_o
);

  logic [N_TERMS-1:0] term;

  for (genvar n = 0; n < N_TERMS; n++) begin : g_term
    logic [N_IN-1:0] lit;

    for (genvar k = 0; k < N_IN; k++) begin : g_lit
      assign lit[k] = lit_pol(n, k, Form) ? x_i[k] : ~x_i[k];
    end

    // Terms not in the expression are tied to the identity of the outer op.
    if (Form == FormSop) begin : g_min
      assign term[n] = Column[n] ? &lit : 1'b0;
    end else begin : g_max
      assign term[n] = Column[n] ? 1'b1 : |lit;
    end
  end

  if (Form == FormSop) begin : g_or
    assign y_o = |term;
  end else begin : g_and
    assign y_o = &term;
  end

endmodule

// File: rtl/ddnf_dknf_9_4.sv
// Registered 9-input popcount computed twice, as a canonical sum of minterms and
// as a canonical product of maxterms, with a flag raised if the two disagree.
module ddnf_dknf_9_4
  import ddnf_dknf_9_4_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic x0,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  input  logic x5,
  input  logic x6,
  input  logic x7,
  input  logic x8,
  output logic y_ddnf0,
  output logic y_ddnf1,
  output logic y_ddnf2,
  output logic y_ddnf3,
  output logic y_dknf0,
  output logic y_dknf1,
  output logic y_dknf2,
  output logic y_dknf3,
  output logic err
);

  logic [N_IN-1:0]  x_vec;
  // Index j matches output name suffix: j = 0 is the MSB.
  logic [0:N_OUT-1] ddnf_d, dknf_d, ddnf_q, dknf_q;
  logic             err_d, err_q;

  assign x_vec = {x8, x7, x6, x5, x4, x3, x2, x1, x0};

  for (genvar j = 0; j < N_OUT; j++) begin : g_bit
    nf_term_eval #(
      .Form   (FormSop),
      .Column (truth_col(j))
    ) u_ddnf (
      .x_i (x_vec),
      .y_o (ddnf_d[j])
    );

    nf_term_eval #(
      .Form   (FormPos),
      .Column (truth_col(j))
    ) u_dknf (
      .x_i (x_vec),
      .y_o (dknf_d[j])
    );
  end

  // Disagreement check on the same values that get registered.
  always_comb begin
    err_d = |(ddnf_d ^ dknf_d);
  end

  // Output register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ddnf_q <= '0;
      dknf_q <= '0;
      err_q  <= 1'b0;
    end else begin
      ddnf_q <= ddnf_d;
      dknf_q <= dknf_d;
      err_q  <= err_d;
    end
  end

  assign y_ddnf0 = ddnf_q[0];
  assign y_ddnf1 = ddnf_q[1];
  assign y_ddnf2 = ddnf_q[2];
  assign y_ddnf3 = ddnf_q[3];
  assign y_dknf0 = dknf_q[0];
  assign y_dknf1 = dknf_q[1];
  assign y_dknf2 = dknf_q[2];
  assign y_dknf3 = dknf_q[3];
  assign err     = err_q;

endmodule

// File: tb/tb_ddnf_dknf_9_4.sv
// Directed and table-driven bench for ddnf_dknf_9_4.
module tb_ddnf_dknf_9_4;

  logic       clk;
  logic       rst;
  logic [8:0] x;
  logic       yd0, yd1, yd2, yd3;
  logic       yk0, yk1, yk2, yk3;
  logic       err;

  logic [3:0] ddnf, dknf;
  assign ddnf = {yd0, yd1, yd2, yd3};
  assign dknf = {yk0, yk1, yk2, yk3};

  int n_checks = 0;
  int n_fail   = 0;

  ddnf_dknf_9_4 dut (
    .clk     (clk),
    .rst     (rst),
    .x0      (x[0]),
    .x1      (x[1]),
    .x2      (x[2]),
    .x3      (x[3]),
    .x4      (x[4]),
    .x5      (x[5]),
    .x6      (x[6]),
    .x7      (x[7]),
    .x8      (x[8]),
    .y_ddnf0 (yd0),
    .y_ddnf1 (yd1),
    .y_ddnf2 (yd2),
    .y_ddnf3 (yd3),
    .y_dknf0 (yk0),
    .y_dknf1 (yk1),
    .y_dknf2 (yk2),
    .y_dknf3 (yk3),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] x;
    logic [3:0] y;
  } vec_t;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Check both forms against one expected code, plus err low.
  task automatic chk_all(input string name, input logic [3:0] exp);
    chk({name, " ddnf"}, ddnf, exp);
    chk({name, " dknf"}, dknf, exp);
    chk({name, " err"}, {3'b000, err}, 4'b0000);
  endtask

  // Drive x, take one edge, sample 1 time unit later.
  task automatic step(input logic [8:0] v);
    x = v;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{9'd0,     4'b0000};
    tbl[1]  = '{9'd7,     4'b0011};
    tbl[2]  = '{9'd256,   4'b0001};
    tbl[3]  = '{9'd255,   4'b1000};
    tbl[4]  = '{9'd510,   4'b1000};
    tbl[5]  = '{9'd511,   4'b1001};
    tbl[6]  = '{9'd1,     4'b0001};
    tbl[7]  = '{9'h155,   4'b0101};
    tbl[8]  = '{9'h0AA,   4'b0100};
    tbl[9]  = '{9'h1F0,   4'b0101};
    tbl[10] = '{9'h00F,   4'b0100};
    tbl[11] = '{9'd257,   4'b0010};
    tbl[12] = '{9'h17F,   4'b1000};

    // Reset with all inputs high clears everything.
    rst = 1'b1;
    x   = 9'h1FF;
    @(posedge clk);
    #1;
    chk("reset ddnf", ddnf, 4'b0000);
    chk("reset dknf", dknf, 4'b0000);
    chk("reset err", {3'b000, err}, 4'b0000);
    rst = 1'b0;
    step(9'h1FF);
    chk_all("post-reset 511", 4'b1001);

    // Directed table.
    foreach (tbl[i]) begin
      step(tbl[i].x);
      chk_all($sformatf("table x=%0d", tbl[i].x), tbl[i].y);
    end

    // Exhaustive sweep, expected from an independent popcount.
    for (int n = 0; n < 512; n++) begin
      step(9'(n));
      chk_all($sformatf("sweep n=%0d", n), 4'($countones(9'(n))));
    end

    // Latency: 0 -> 511 in one cycle.
    step(9'd0);
    chk_all("latency pre", 4'b0000);
    x = 9'd511;
    #1;
    chk_all("latency no-edge", 4'b0000);
    @(posedge clk);
    #1;
    chk_all("latency one-edge", 4'b1001);

    // Mid-sweep reset at n=300.
    for (int n = 295; n < 300; n++) begin
      step(9'(n));
      chk_all($sformatf("midsweep n=%0d", n), 4'($countones(9'(n))));
    end
    rst = 1'b1;
    step(9'd300);
    chk_all("midsweep reset", 4'b0000);
    rst = 1'b0;
    step(9'd301);
    chk_all("midsweep resume 301", 4'b0101);
    step(9'd302);
    chk_all("midsweep 302", 4'b0101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
